// File: rtl/wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the register file.
// The slave modport is the arbiter's view; the master modport is the requesters/regfile view.
interface wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       busy;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, busy
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-requester register-file write-port arbiter with one holding entry per requester,
// alternating priority under contention and a per-register busy scoreboard.
module wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  typedef enum logic [0:0] {GrantA, GrantB} grant_e;

  logic              a_full_q, a_full_d, b_full_q, b_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  grant_e            last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic grant_a, grant_b;
  logic accept_a, accept_b;

  // Under contention the requester that was not served last wins.
  assign grant_a = a_full_q && (!b_full_q || (last_q == GrantB));
  assign grant_b = b_full_q && (!a_full_q || (last_q == GrantA));

  assign bus.a_ready = !a_full_q || grant_a;
  assign bus.b_ready = !b_full_q || grant_b;

  // Writes to register 0 complete the handshake but are dropped.
  assign accept_a = bus.a_valid && bus.a_ready && (bus.a_addr != '0);
  assign accept_b = bus.b_valid && bus.b_ready && (bus.b_addr != '0);

  always_comb begin
    a_full_d  = a_full_q;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    b_full_d  = b_full_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (grant_a) begin
      wr_en_d   = 1'b1;
      wr_addr_d = a_addr_q;
      wr_data_d = a_data_q;
      last_d    = GrantA;
      a_full_d  = 1'b0;
    end else if (grant_b) begin
      wr_en_d   = 1'b1;
      wr_addr_d = b_addr_q;
      wr_data_d = b_data_q;
      last_d    = GrantB;
      b_full_d  = 1'b0;
    end

    if (accept_a) begin
      a_full_d = 1'b1;
      a_addr_d = bus.a_addr;
      a_data_d = bus.a_data;
    end
    if (accept_b) begin
      b_full_d = 1'b1;
      b_addr_d = bus.b_addr;
      b_data_d = bus.b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_q  <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      b_full_q  <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      last_q    <= GrantB;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      a_full_q  <= a_full_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      b_full_q  <= b_full_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  logic [31:0] busy_a, busy_b;
  assign busy_a   = a_full_q ? (32'd1 << a_addr_q) : 32'd0;
  assign busy_b   = b_full_q ? (32'd1 << b_addr_q) : 32'd0;
  assign bus.busy = (busy_a | busy_b) & ~32'd1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued when stimulus is issued
// and a monitor pops and compares them whenever the register-file strobe fires.
module tb_wb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_a(input logic v, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    bus.a_valid = v;
    bus.a_addr  = addr;
    bus.a_data  = data;
  endtask

  task automatic drive_b(input logic v, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    bus.b_valid = v;
    bus.b_addr  = addr;
    bus.b_data  = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Monitor: every issued write must match the head of the expected queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n === 1'b1 && bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                 bus.wr_addr, bus.wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", bus.wr_data, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    cyc();
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_a_ready", 32'(bus.a_ready), 32'd1);
    chk("rst_b_ready", 32'(bus.b_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // A only: two-cycle accept-to-write latency, busy while held.
    drive_a(1'b1, 5'd3, 32'h1234);
    push(5'd3, 32'h1234);
    cyc();
    drive_a(1'b0, '0, '0);
    chk("a_only_busy", bus.busy, 32'h0000_0008);
    chk("a_only_no_early_wr", 32'(bus.wr_en), 32'd0);
    cyc();
    chk("a_only_wr_en", 32'(bus.wr_en), 32'd1);
    chk("a_only_busy_clr", bus.busy, 32'd0);
    cyc();
    chk("a_only_single", 32'(bus.wr_en), 32'd0);

    // Simultaneous after reset: A wins first, B held off one cycle.
    do_reset();
    drive_a(1'b1, 5'd5, 32'hA);
    drive_b(1'b1, 5'd6, 32'hB);
    push(5'd5, 32'hA);
    push(5'd6, 32'hB);
    cyc();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    chk("sim_b_ready", 32'(bus.b_ready), 32'd0);
    chk("sim_a_ready", 32'(bus.a_ready), 32'd1);
    chk("sim_busy", bus.busy, 32'h0000_0060);
    cyc();
    chk("sim_wr_a", 32'(bus.wr_en), 32'd1);
    chk("sim_b_ready2", 32'(bus.b_ready), 32'd1);
    cyc();
    chk("sim_wr_b", 32'(bus.wr_en), 32'd1);
    cyc();
    chk("sim_idle", 32'(bus.wr_en), 32'd0);

    // Continuous contention for 8 edges: 9 back-to-back writes A,B,A,B,A,B,A,B,A.
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) push(5'd10, 32'hA0);
      else push(5'd11, 32'hB0);
    end
    drive_a(1'b1, 5'd10, 32'hA0);
    drive_b(1'b1, 5'd11, 32'hB0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i > 0) chk("cont_no_gap", 32'(bus.wr_en), 32'd1);
    end
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("cont_drain", 32'(bus.wr_en), 32'd1);
    end
    cyc();
    chk("cont_idle", 32'(bus.wr_en), 32'd0);

    // B only; also leaves last grant on B for the same-address case.
    drive_b(1'b1, 5'd9, 32'h99);
    push(5'd9, 32'h99);
    cyc();
    drive_b(1'b0, '0, '0);
    chk("b_only_busy", bus.busy, 32'h0000_0200);
    cyc();
    chk("b_only_wr_en", 32'(bus.wr_en), 32'd1);
    cyc();

    // Zero address: accepted and dropped.
    drive_b(1'b1, 5'd0, 32'hFFFF);
    chk("zero_b_ready", 32'(bus.b_ready), 32'd1);
    cyc();
    drive_b(1'b0, '0, '0);
    chk("zero_busy", bus.busy, 32'd0);
    chk("zero_wr_en", 32'(bus.wr_en), 32'd0);
    cyc();
    chk("zero_wr_en2", 32'(bus.wr_en), 32'd0);

    // Same address from both: A then B.
    drive_a(1'b1, 5'd7, 32'd1);
    drive_b(1'b1, 5'd7, 32'd2);
    push(5'd7, 32'd1);
    push(5'd7, 32'd2);
    cyc();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    chk("same_busy", bus.busy, 32'h0000_0080);
    cyc();
    cyc();
    cyc();
    chk("same_idle", 32'(bus.wr_en), 32'd0);

    // Reset mid-flight: held entries are discarded, nothing issued afterwards.
    drive_a(1'b1, 5'd12, 32'hC);
    drive_b(1'b1, 5'd13, 32'hD);
    cyc();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    chk("mid_busy", bus.busy, 32'h0000_3000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 32'd0);
    chk("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("mid_rst_a_ready", 32'(bus.a_ready), 32'd1);
    chk("mid_rst_b_ready", 32'(bus.b_ready), 32'd1);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_wr_en", 32'(bus.wr_en), 32'd0);
    end

    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a_valid  input  1  requester A (ALU writeback) has a write to offer.
REQ-006 a_ready  output  1  requester A write is accepted this cycle when a_valid && a_ready.
REQ-007 a_addr  input  ADDR_W  requester A destination register.
REQ-008 a_data  input  DATA_W  requester A write data.
REQ-009 b_valid, b_ready, b_addr, b_data  same directions and widths as A; requester B (load writeback).
REQ-010 wr_en  output  1  register file write strobe, registered.
REQ-011 wr_addr  output  ADDR_W  register file write address, registered.
REQ-012 wr_data  output  DATA_W  register file write data, registered.
REQ-013 busy  output  32  busy[k]=1 iff a held, not yet written entry targets register k.

Function
REQ-014 The block SHALL share the single register file write port between A and B; exactly one write SHALL be issued per cycle at most.
REQ-015 Each requester SHALL own a one-entry holding register (full flag, addr, data).
REQ-016 Acceptance: on a rising edge where x_valid && x_ready, x_addr != 0, the holding register SHALL load x_addr/x_data and set full.
REQ-017 An accepted request with x_addr == 0 SHALL be discarded: handshake completes, holding register unchanged, no write ever issued.
REQ-018 x_ready SHALL equal !x_full || x_grant; it SHALL depend only on state, never on x_valid.
REQ-019 Arbitration (combinational on holding state): only A full -> grant A; only B full -> grant B; both full -> grant the requester not granted last; neither -> no grant.
REQ-020 A last_grant flag SHALL update on every edge with a grant to the granted requester, and hold otherwise.
REQ-021 On an edge with grant to x: wr_en<=1, wr_addr<=x addr, wr_data<=x data; x holding register SHALL clear full unless a new request is accepted the same edge, in which case it SHALL reload.
REQ-022 On an edge with no grant: wr_en<=0; wr_addr and wr_data SHALL hold their previous values.
REQ-023 Latency: an uncontested request accepted on edge E SHALL appear with wr_en=1 after edge E+1 (two-cycle accept-to-write); sustained single-requester throughput SHALL be one write per cycle.
REQ-024 Under continuous contention, A and B SHALL alternate strictly; neither SHALL wait more than one grant.
REQ-025 Same-address writes from A and B SHALL be issued in grant order; the later grant SHALL be the final register value.
REQ-026 busy SHALL be the OR of one-hot decodes of the full holding registers' addresses; busy[0] SHALL always be 0.
REQ-027 wr_addr SHALL never be 0 while wr_en=1.

Reset
REQ-028 While rst_n=0: both full flags 0, wr_en=0, wr_addr=0, wr_data=0, last_grant=B (A wins first contention), busy=0, a_ready=b_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard held entries without issuing writes; deassertion SHALL be synchronised so the first post-reset edge behaves as REQ-028 state.

Verification
REQ-030 A only: a_valid=1, a_addr=3, a_data=0x1234 on edge 1 -> wr_en=1, wr_addr=3, wr_data=0x1234 after edge 2, busy[3]=1 between edges 1 and 2.
REQ-031 Simultaneous: A(addr 5, 0xA) and B(addr 6, 0xB) on edge 1 after reset -> A written after edge 2, B after edge 3, b_ready=0 during cycle after edge 1.
REQ-032 Continuous contention: both valid every cycle, 8 cycles -> wr_addr source alternates A,B,A,B; no gap cycles with wr_en=0 after the first.
REQ-033 Zero address: b_valid, b_addr=0, b_data=0xFFFF -> b_ready=1, wr_en stays 0, busy stays 0.
REQ-034 Same address: A(addr 7, 1) and B(addr 7, 2) together -> two writes to 7 in order A then B.
REQ-035 Reset mid-flight: both holding full, rst_n pulsed low -> wr_en=0, busy=0, no pending write issued after release.
